// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and FSM state encoding (TX and RX).
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int TICK_W     = 4;
    localparam int BIT_W      = 3;

    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : rx_sync
// Description : 2-flop synchronizer for the rx pad, resets to idle-high.
//               Only exists in builds with UART_RX_SYNC_EN defined.
// Revision    : 1.0
// ============================================================================
`ifdef UART_RX_SYNC_EN
module rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], din};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[1];

endmodule
`endif
`default_nettype wire

// File: rtl/receiver.sv
`default_nettype none
// ============================================================================
// Module      : receiver
// Description : UART 8N1 receive path, 16x oversampled via baud_tick.
//               Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer.
// Revision    : 1.0
// ============================================================================
module receiver
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_busy,
    output logic       rx_done,
    output logic       rx_frame_err
);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    rx_sync u_rx_sync (
        .clk  (clk),
        .rstn (rstn),
        .din  (rx),
        .dout (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    uart_state_e       state_q,    state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]        shift_q,    shift_d;
    logic [7:0]        rx_data_q,  rx_data_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              ferr_q,     ferr_d;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ferr_d     = ferr_q;

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                        busy_d     = 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt_q != MID_TICK) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end else if (!rx_s) begin
                        state_d    = DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as noise.
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                    end
                end
                DATA: begin
                    if (tick_cnt_q != LAST_TICK) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end else begin
                        shift_d    = {rx_s, shift_q[7:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick_cnt_q != LAST_TICK) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end else begin
                        rx_data_d = shift_q;
                        ferr_d    = ~rx_s;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_busy      = busy_q;
    assign rx_done      = done_q;
    assign rx_frame_err = ferr_q;

endmodule
`default_nettype wire
